// File: rtl/ip_mem_if.sv
// rtl/ip_mem_if.sv - LSU load/store port bundle for the switch/button I/O block
interface ip_mem_if;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_wren;
    logic [31:0] i_st_data;
    logic [31:0] o_ip_data;

    modport master (
        output i_lsu_addr,
        output i_lsu_wren,
        output i_st_data,
        input  o_ip_data
    );

    modport slave (
        input  i_lsu_addr,
        input  i_lsu_wren,
        input  i_st_data,
        output o_ip_data
    );
endinterface

// File: rtl/ip_mem.sv
// rtl/ip_mem.sv - memory-mapped switch and debounced push-button registers
module ip_mem #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ip_mem_if.slave     bus,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic        o_btn_event
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]      sw_s1, sw_s2;
    logic [3:0]       btn_s1, btn_s2;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       deb, cap, raw, rise, clr;
    logic             sel;
    logic [4:0]       idx;
    logic [31:0]      rd_next, rd_q;
    logic             unused_bits;

    // Buttons idle high on the pins, so their synchronizers reset to "released".
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 4'hF;
            btn_s2 <= 4'hF;
        end else begin
            sw_s1  <= i_io_sw;
            sw_s2  <= sw_s1;
            btn_s1 <= i_io_btn;
            btn_s2 <= btn_s1;
        end
    end

    assign raw = ~btn_s2;
    assign sel = (bus.i_lsu_addr[15:7] == 9'h0F0);
    assign idx = bus.i_lsu_addr[6:2];
    assign clr = (sel && bus.i_lsu_wren && idx == 5'd5) ? bus.i_st_data[3:0] : 4'h0;

    always_comb begin
        rise = '0;
        for (int n = 0; n < 4; n++) begin
            rise[n] = raw[n] & ~deb[n] & (cnt[n] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            deb <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (raw[n] == deb[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == CNT_MAX) begin
                    deb[n] <= raw[n];
                    cnt[n] <= '0;
                end else begin
                    cnt[n] <= cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as a clear must not be lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cap <= '0;
        end else begin
            cap <= (cap & ~clr) | rise;
        end
    end

    always_comb begin
        rd_next = '0;
        if (sel) begin
            case (idx)
                5'd0:    rd_next = sw_s2;
                5'd4:    rd_next = {28'b0, deb};
                5'd5:    rd_next = {28'b0, cap};
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_next;
        end
    end

    assign bus.o_ip_data = rd_q;
    assign o_btn_event   = |cap;
    assign unused_bits   = ^{bus.i_lsu_addr[31:16], bus.i_lsu_addr[1:0], bus.i_st_data[31:4]};
endmodule

// File: tb/tb_ip_mem.sv
// tb/tb_ip_mem.sv - directed self-checking bench for ip_mem with DEBOUNCE_CYCLES = 4
module tb_ip_mem;
    logic        clk;
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic        btn_event;
    int          tests;
    int          fails;
    logic [31:0] rdata;

    ip_mem_if bus ();

    ip_mem #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .i_io_sw    (sw),
        .i_io_btn   (btn),
        .o_btn_event(btn_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.i_lsu_addr = addr;
        bus.i_lsu_wren = 1'b0;
        tick();
        data = bus.o_ip_data;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.i_lsu_addr = addr;
        bus.i_lsu_wren = 1'b1;
        bus.i_st_data  = data;
        tick();
        bus.i_lsu_wren = 1'b0;
        bus.i_st_data  = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.o_ip_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_ip_data: got %h expected %h", bus.o_ip_data, 32'h0);
        end
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL reset_btn_event: got %b expected 0", btn_event);
        end
        tick(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sw;
        bus.i_lsu_addr = 32'h7800;
        tick(2);
        sw = 32'hA5A5_0F0F;
        tick(2);
        tests++;
        if (bus.o_ip_data !== 32'h0) begin
            fails++;
            $display("FAIL sw_early: got %h expected %h", bus.o_ip_data, 32'h0);
        end
        tick();
        tests++;
        if (bus.o_ip_data !== 32'hA5A5_0F0F) begin
            fails++;
            $display("FAIL sw_third_edge: got %h expected %h", bus.o_ip_data, 32'hA5A5_0F0F);
        end
        tick(3);
        tests++;
        if (bus.o_ip_data !== 32'hA5A5_0F0F) begin
            fails++;
            $display("FAIL sw_stable: got %h expected %h", bus.o_ip_data, 32'hA5A5_0F0F);
        end
    endtask

    task automatic test_btn_press;
        bus.i_lsu_addr = 32'h7000;
        btn = 4'b1011;
        tick(5);
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL press_too_early: got %b expected 0", btn_event);
        end
        tick();
        tests++;
        if (btn_event !== 1'b1) begin
            fails++;
            $display("FAIL press_event: got %b expected 1", btn_event);
        end
        rd(32'h7810, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL press_btn_level: got %h expected %h", rdata, 32'h4);
        end
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL press_capture: got %h expected %h", rdata, 32'h4);
        end
        btn = 4'hF;
        tick(10);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL release_keeps_capture: got %h expected %h", rdata, 32'h4);
        end
        rd(32'h7810, rdata);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL release_level: got %h expected %h", rdata, 32'h0);
        end
    endtask

    task automatic test_bounce;
        wr(32'h7814, 32'h4);
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL bounce_pre_clear: got %b expected 0", btn_event);
        end
        bus.i_lsu_addr = 32'h7000;
        btn = 4'b1110;
        tick(3);
        btn = 4'b1111;
        tick();
        btn = 4'b1110;
        tick(5);
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL bounce_early_capture: got %b expected 0", btn_event);
        end
        tick();
        tests++;
        if (btn_event !== 1'b1) begin
            fails++;
            $display("FAIL bounce_capture_edge: got %b expected 1", btn_event);
        end
        tick(4);
        btn = 4'hF;
        tick(10);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h1) begin
            fails++;
            $display("FAIL bounce_single_capture: got %h expected %h", rdata, 32'h1);
        end
    endtask

    task automatic test_clear;
        btn = 4'b1011;
        tick(8);
        btn = 4'hF;
        tick(8);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h5) begin
            fails++;
            $display("FAIL clear_pre: got %h expected %h", rdata, 32'h5);
        end
        wr(32'h7814, 32'h1);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL clear_bit0: got %h expected %h", rdata, 32'h4);
        end
        wr(32'h7814, 32'h4);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL clear_bit2: got %h expected %h", rdata, 32'h0);
        end
        btn = 4'b1011;
        tick(5);
        wr(32'h7814, 32'h4);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL set_beats_clear: got %h expected %h", rdata, 32'h4);
        end
        tests++;
        if (btn_event !== 1'b1) begin
            fails++;
            $display("FAIL set_beats_clear_event: got %b expected 1", btn_event);
        end
        btn = 4'hF;
        tick(8);
    endtask

    task automatic test_decode;
        rd(32'h7808, rdata);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL unmapped_index: got %h expected %h", rdata, 32'h0);
        end
        rd(32'h7900, rdata);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL unselected_block: got %h expected %h", rdata, 32'h0);
        end
        wr(32'h7800, 32'hFFFF_FFFF);
        sw = 32'h1234_5678;
        bus.i_lsu_addr = 32'h7800;
        tick(3);
        tests++;
        if (bus.o_ip_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL sw_after_write: got %h expected %h", bus.o_ip_data, 32'h1234_5678);
        end
        wr(32'h7810, 32'hFFFF_FFFF);
        rd(32'h7814, rdata);
        tests++;
        if (rdata !== 32'h4) begin
            fails++;
            $display("FAIL btn_write_no_clear: got %h expected %h", rdata, 32'h4);
        end
        rd(32'h7813, rdata);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL btn_low_bits_ignored: got %h expected %h", rdata, 32'h0);
        end
    endtask

    task automatic test_reset_mid;
        btn = 4'h0;
        tick(8);
        btn = 4'hF;
        tick(8);
        bus.i_lsu_addr = 32'h7814;
        btn = 4'b1101;
        tick(4);
        tests++;
        if (bus.o_ip_data !== 32'hF) begin
            fails++;
            $display("FAIL pre_reset_capture: got %h expected %h", bus.o_ip_data, 32'hF);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.o_ip_data !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_data: got %h expected %h", bus.o_ip_data, 32'h0);
        end
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_event: got %b expected 0", btn_event);
        end
        tick(2);
        rst = 1'b1;
        bus.i_lsu_addr = 32'h7810;
        tick(5);
        tests++;
        if (btn_event !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_early: got %b expected 0", btn_event);
        end
        tick();
        tests++;
        if (btn_event !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_press: got %b expected 1", btn_event);
        end
        tick();
        tests++;
        if (bus.o_ip_data !== 32'h2) begin
            fails++;
            $display("FAIL post_reset_level: got %h expected %h", bus.o_ip_data, 32'h2);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sw = '0;
        btn = 4'hF;
        bus.i_lsu_addr = '0;
        bus.i_lsu_wren = 1'b0;
        bus.i_st_data  = '0;
        test_reset();
        test_sw();
        test_btn_press();
        test_bounce();
        test_clear();
        test_decode();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
